stp_collector: RTL and testbench



---
 rtl/stp_collector.sv | 76 +++++++
 tb/tb_stp_collector.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stp_collector.sv
// Serial-to-parallel frame collector: gathers DEPTH words of WIDTH bits
// into a double-buffered parallel frame with a valid/ack handshake.
module stp_collector #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           datain,
    input  logic                       in_valid,
    input  logic                       sync,
    input  logic                       frame_ack,
    output logic [WIDTH*DEPTH-1:0]     dataout,
    output logic                       frame_valid,
    output logic                       overrun,
    output logic [$clog2(DEPTH)-1:0]   count
);

    localparam int CW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    logic [WIDTH-1:0]       fill [DEPTH-1];
    logic [WIDTH*DEPTH-1:0] next_frame;
    logic                   done;

    // The final word bypasses the fill buffer straight into the frame.
    always_comb begin
        next_frame = '0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            next_frame[k*WIDTH +: WIDTH] = fill[k];
        end
        next_frame[(DEPTH-1)*WIDTH +: WIDTH] = datain;
    end

    assign done = in_valid && !sync && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            dataout     <= '0;
            for (int k = 0; k < DEPTH - 1; k++) begin
                fill[k] <= '0;
            end
        end else begin
            if (in_valid) begin
                if (sync) begin
                    fill[0] <= datain;
                    count   <= CW'(1);
                end else if (count == LAST) begin
                    dataout <= next_frame;
                    count   <= '0;
                end else begin
                    fill[count] <= datain;
                    count       <= count + CW'(1);
                end
            end else if (sync) begin
                count <= '0;
            end

            if (done) begin
                frame_valid <= 1'b1;
            end else if (frame_ack) begin
                frame_valid <= 1'b0;
            end

            if (done && frame_valid && !frame_ack) begin
                overrun <= 1'b1;
            end else if (sync) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stp_collector.sv
// Directed bench for stp_collector: fill, gaps, sync, handshake,
// back-to-back frames and asynchronous reset.
module tb_stp_collector;

    localparam int W = 25;
    localparam int D = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W-1:0]     datain = '0;
    logic             in_valid = 1'b0;
    logic             sync = 1'b0;
    logic             frame_ack = 1'b0;
    logic [W*D-1:0]   dataout;
    logic             frame_valid;
    logic             overrun;
    logic [4:0]       count;

    int total = 0;
    int bad = 0;

    stp_collector #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .datain(datain),
        .in_valid(in_valid),
        .sync(sync),
        .frame_ack(frame_ack),
        .dataout(dataout),
        .frame_valid(frame_valid),
        .overrun(overrun),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [W*D-1:0] mk(input int base);
        logic [W*D-1:0] r;
        r = '0;
        for (int k = 0; k < D; k++) r[k*W +: W] = W'(base + k);
        return r;
    endfunction

    // One clock: inputs applied, edge taken, outputs sampled 1ns later.
    task automatic step(input int d, input logic v, input logic s,
                        input logic a);
        datain = W'(d);
        in_valid = v;
        sync = s;
        frame_ack = a;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sync = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        total++;
        if (count !== 5'd0 || frame_valid !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: cnt=%0d fv=%b ov=%b want 0 0 0",
                     count, frame_valid, overrun);
        end
        total++;
        if (dataout !== '0) begin
            bad++;
            $display("FAIL reset_data: dataout nonzero, want 0");
        end
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        for (int i = 0; i < D - 1; i++) step(1 + i, 1, 0, 0);
        total++;
        if (count !== 5'd19 || frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_partial: cnt=%0d fv=%b want 19 0",
                     count, frame_valid);
        end
        step(20, 1, 0, 0);
        total++;
        if (frame_valid !== 1'b1 || count !== 5'd0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: fv=%b cnt=%0d ov=%b want 1 0 0",
                     frame_valid, count, overrun);
        end
        total++;
        if (dataout !== mk(1)) begin
            bad++;
            $display("FAIL basic_data: got %h want %h", dataout, mk(1));
        end
        step(0, 0, 0, 1);
        total++;
        if (frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_ack: fv=%b want 0", frame_valid);
        end
    endtask

    task automatic test_gapped;
        int errs;
        errs = 0;
        for (int i = 0; i < D; i++) begin
            step(100 + i, 1, 0, 0);
            if (i < D - 1) begin
                if (count !== 5'(i + 1)) errs++;
                step(7777, 0, 0, 0);
                if (count !== 5'(i + 1) || frame_valid !== 1'b0) errs++;
            end
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL gapped_count: %0d bad count samples want 0", errs);
        end
        total++;
        if (frame_valid !== 1'b1 || dataout !== mk(100)) begin
            bad++;
            $display("FAIL gapped_frame: fv=%b got %h want %h",
                     frame_valid, dataout, mk(100));
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_sync;
        for (int i = 0; i < 7; i++) step(600 + i, 1, 0, 0);
        total++;
        if (count !== 5'd7) begin
            bad++;
            $display("FAIL sync_pre: cnt=%0d want 7", count);
        end
        step(500, 1, 1, 0);
        total++;
        if (count !== 5'd1 || frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL sync_cnt: cnt=%0d fv=%b want 1 0",
                     count, frame_valid);
        end
        for (int i = 1; i < D; i++) step(500 + i, 1, 0, 0);
        total++;
        if (frame_valid !== 1'b1 || dataout !== mk(500)) begin
            bad++;
            $display("FAIL sync_frame: fv=%b got %h want %h",
                     frame_valid, dataout, mk(500));
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_overrun;
        for (int i = 0; i < D; i++) step(1000 + i, 1, 0, 0);
        for (int i = 0; i < D; i++) step(2000 + i, 1, 0, 0);
        total++;
        if (frame_valid !== 1'b1 || overrun !== 1'b1 ||
            dataout !== mk(2000)) begin
            bad++;
            $display("FAIL ovr_set: fv=%b ov=%b data_ok=%b want 1 1 1",
                     frame_valid, overrun, dataout === mk(2000));
        end
        step(0, 0, 1, 0);
        total++;
        if (overrun !== 1'b0 || frame_valid !== 1'b1 ||
            dataout !== mk(2000)) begin
            bad++;
            $display("FAIL ovr_sync: ov=%b fv=%b data_ok=%b want 0 1 1",
                     overrun, frame_valid, dataout === mk(2000));
        end
        for (int i = 0; i < D - 1; i++) step(3000 + i, 1, 0, 0);
        step(3000 + D - 1, 1, 0, 1);
        total++;
        if (frame_valid !== 1'b1 || overrun !== 1'b0 ||
            dataout !== mk(3000)) begin
            bad++;
            $display("FAIL ovr_ackdone: fv=%b ov=%b data_ok=%b want 1 0 1",
                     frame_valid, overrun, dataout === mk(3000));
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < D; i++) step(4000 + i, 1, 0, 0);
        total++;
        if (frame_valid !== 1'b1 || dataout !== mk(4000)) begin
            bad++;
            $display("FAIL b2b_first: fv=%b got %h want %h",
                     frame_valid, dataout, mk(4000));
        end
        step(4000 + D, 1, 0, 1);
        total++;
        if (frame_valid !== 1'b0 || count !== 5'd1) begin
            bad++;
            $display("FAIL b2b_ack: fv=%b cnt=%0d want 0 1",
                     frame_valid, count);
        end
        for (int i = D + 1; i < 2 * D; i++) step(4000 + i, 1, 0, 0);
        total++;
        if (frame_valid !== 1'b1 || overrun !== 1'b0 ||
            dataout !== mk(4000 + D)) begin
            bad++;
            $display("FAIL b2b_second: fv=%b ov=%b got %h want %h",
                     frame_valid, overrun, dataout, mk(4000 + D));
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 12; i++) step(9000 + i, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (count !== 5'd0 || frame_valid !== 1'b0 || overrun !== 1'b0 ||
            dataout !== '0) begin
            bad++;
            $display("FAIL async_rst: cnt=%0d fv=%b ov=%b data0=%b want 0 0 0 1",
                     count, frame_valid, overrun, dataout === '0);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < D; i++) step(5000 + i, 1, 0, 0);
        total++;
        if (frame_valid !== 1'b1 || overrun !== 1'b0 ||
            dataout !== mk(5000)) begin
            bad++;
            $display("FAIL async_clean: fv=%b ov=%b got %h want %h",
                     frame_valid, overrun, dataout, mk(5000));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_sync();
        test_overrun();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
